vga_vram_reader: RTL
====================

# vga_vram_reader

Scan-out engine on the display side of the three 1-bit VRAM channels (red, green, blue), each a 16K×1 single-port block RAM holding a 128×96 image. The block generates 640×480@60 Hz VGA timing from the system clock and drives the shared 14-bit VRAM read address. It upscales each stored pixel to a 5×5 screen block and realigns the synchronous BRAM read data with the delayed sync signals. Its outputs drive the board's 4-bit-per-colour VGA connector.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel clock; 100 MHz ÷ 4 gives 25 MHz.
- SCALE, 5: screen pixels per stored pixel, applied both horizontally and vertically.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: synchronous reset, active-high.
- red_in, input, 1: VRAM red data out. Valid one clk after `address` changes.
- green_in, input, 1: VRAM green data out. Same timing as red_in.
- blue_in, input, 1: VRAM blue data out. Same timing as red_in.
- address, output, 14: shared VRAM read address, formed as {row[6:0], col[6:0]}.
- vga_red, output, 4: red output. Either 4'hF or 4'h0.
- vga_green, output, 4: green output. Either 4'hF or 4'h0.
- vga_blue, output, 4: blue output. Either 4'hF or 4'h0.
- hsync, output, 1: horizontal sync, active-low.
- vsync, output, 1: vertical sync, active-low.

## Operation
- Divider: counts 0..CLK_DIV-1. `tick` is asserted for one clk when the divider equals CLK_DIV-1.
- Horizontal counter: hcount 0..799, advances on each tick.
  - Visible: 0–639. Front porch: 640–655. Sync: 656–751. Back porch: 752–799.
- Vertical counter: vcount 0..524, advances on a tick when hcount wraps from 799 to 0.
  - Visible: 0–479. Front porch: 480–489. Sync: 490–491. Back porch: 492–524.
- Upscale counters: used in place of a divider or multiplier.
  - xsub counts 0..SCALE-1; col increments when xsub wraps. Both clear at hcount = 799.
  - ysub counts 0..SCALE-1; row increments when ysub wraps. Both clear at vcount = 524. They advance only at the end of a visible line.
- Address: equals {row, col} while hcount and vcount are both visible. Otherwise it holds its last value.
  - Range is 0x0000–0x2FFF; the top row is 95 (0x5F).
- Pipeline, three stages:
  - Stage 0: counters update on tick.
  - Stage 1: the address register updates on the clk after tick. The stage-0 blank/hsync/vsync flags are copied to stage 1.
  - Stage 2: BRAM data appears. On the clk two cycles after tick, the colour outputs and hsync/vsync are registered together.
- Colour: vga_* = {4{*_in}} when the stage-2 visible flag is 1, else 4'h0. Blanking always wins, even if the VRAM data is 1.
- Simultaneous hcount and vcount wrap: both wrap on the same tick, and address returns to 0 for the next frame.
- Reset mid-frame: all counters, the divider and the pipeline clear on the next clk. Scanning restarts at pixel (0,0) with no partial state kept.

## Timing
- Reset values:
  - address = 0.
  - vga_red, vga_green, vga_blue = 0.
  - hsync = 1, vsync = 1.
  - All counters = 0.
- Line length is 800 × CLK_DIV clk, which is 3200 clk.
- Frame length is 525 lines.
- hsync is low for 96 × CLK_DIV = 384 clk.
- vsync is low for 2 lines = 6400 clk.
- Latency: the colour outputs and syncs lag the stage-0 counter update by exactly 2 clk. Syncs and colours stay mutually aligned.

## Configuration
- TEST_PATTERN_EN defined: red_in, green_in and blue_in are ignored.
  - The colour source is replaced by an 8-colour bar pattern, with colour index = col[6:4].
  - Timing, latency and blanking are unchanged.
  - address is still driven.
- TEST_PATTERN_EN undefined: colours come from the VRAM inputs as described in Operation.

## Structure
- Package vga_timing_pkg holds:
  - Localparams H_VISIBLE, H_FRONT, H_SYNC, H_BACK, H_TOTAL.
  - The matching V_* localparams.
  - IMG_W = 128 and IMG_H = 96.
  - Typedef for a 10-bit screen coordinate.
- Sub-module vga_sync_counter contains the divider, hcount/vcount, and the raw visible/hsync/vsync flags.
- The top level adds the upscale counters, the address register, the two-stage alignment pipeline and colour gating.

## Test plan
- Sync timing: reset for 2 clk, then run one frame.
  - Required: hsync falling edges are 3200 clk apart, each low pulse is 384 clk, and the vsync low pulse is 6400 clk.
- Address scan:
  - Required: address = 0x0000 at screen (0,0), 0x0001 at x = 5, 0x0080 at (0,5), and 0x2FFF at (639,479).
- Data alignment: a BRAM model returns red_in = 1 only for address 0.
  - Required: vga_red = 4'hF exactly for x 0–4, y 0–4.
  - Required: vga_red is 4'h0 everywhere else, and goes high 2 clk after the counter tick for x = 0.
- Blanking: hold red_in, green_in and blue_in at 1.
  - Required: all colour outputs are 4'h0 for hcount ≥ 640 or vcount ≥ 480, and 4'hF in the visible area.
- Reset mid-frame: assert reset at vcount = 200.
  - Required: on the next clk, address = 0, hsync = 1, vsync = 1 and colours = 0.
  - Required: after release, the first hsync falling edge occurs 656 × 4 + 2 = 2626 clk later.
- With TEST_PATTERN_EN defined and all VRAM inputs at 0:
  - Required: at col = 0x10, i.e. x = 80, the output is colour index 1, so vga_blue = 4'hF.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz timing constants and coordinate type
// shared by the VGA scan-out blocks.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FRONT   = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BACK    = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FRONT   = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BACK    = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST       = H_TOTAL - 10'd1;
    localparam coord_t V_LAST       = V_TOTAL - 10'd1;
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int IMG_W = 128;
    localparam int IMG_H = 96;

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel-clock divider, h/v raster counters and the
// raw (stage-0) visible / hsync / vsync flags.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   reset,
    output logic   tick_o,
    output coord_t hcount_o,
    output coord_t vcount_o,
    output logic   visible_o,
    output logic   hsync_o,
    output logic   vsync_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    coord_t           hcount_q, hcount_d;
    coord_t           vcount_q, vcount_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    // Next-state for the divider and the raster counters
    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign tick_o    = tick;
    assign hcount_o  = hcount_q;
    assign vcount_o  = vcount_q;
    assign visible_o = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
    assign hsync_o   = ~((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
    assign vsync_o   = ~((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));

endmodule

// File: rtl/vga_vram_reader.sv
// vga_vram_reader: 640x480 scan-out of a 128x96 1-bit-per-colour VRAM,
// 5x upscaled. Define TEST_PATTERN_EN to replace VRAM data with colour bars.
module vga_vram_reader
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SCALE   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red_in,
    input  logic        green_in,
    input  logic        blue_in,
    output logic [13:0] address,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        hsync,
    output logic        vsync
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

    logic   tick;
    coord_t hcount, vcount;
    logic   vis0, hs0, vs0;

    vga_sync_counter #(
        .CLK_DIV (CLK_DIV)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .tick_o    (tick),
        .hcount_o  (hcount),
        .vcount_o  (vcount),
        .visible_o (vis0),
        .hsync_o   (hs0),
        .vsync_o   (vs0)
    );

    logic [SUB_W-1:0] xsub_q, xsub_d, ysub_q, ysub_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Upscale counters: step alongside hcount/vcount, no divider needed
    always_comb begin
        xsub_d = xsub_q;
        col_d  = col_q;
        ysub_d = ysub_q;
        row_d  = row_q;
        if (tick) begin
            if (hcount == H_LAST) begin
                xsub_d = '0;
                col_d  = '0;
                if (vcount == V_LAST) begin
                    ysub_d = '0;
                    row_d  = '0;
                end else if (vcount < V_VISIBLE) begin
                    if (ysub_q == SUB_LAST) begin
                        ysub_d = '0;
                        row_d  = row_q + ROW_W'(1);
                    end else begin
                        ysub_d = ysub_q + SUB_W'(1);
                    end
                end
            end else if (hcount < H_VISIBLE) begin
                if (xsub_q == SUB_LAST) begin
                    xsub_d = '0;
                    col_d  = col_q + COL_W'(1);
                end else begin
                    xsub_d = xsub_q + SUB_W'(1);
                end
            end
        end
    end

    // Upscale counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            xsub_q <= '0;
            col_q  <= '0;
            ysub_q <= '0;
            row_q  <= '0;
        end else begin
            xsub_q <= xsub_d;
            col_q  <= col_d;
            ysub_q <= ysub_d;
            row_q  <= row_d;
        end
    end

    logic [13:0] address_q, address_d;
    logic        vis1_q, hs1_q, vs1_q;
    logic [2:0]  src;

    assign address_d = vis0 ? {row_q, col_q} : address_q;

`ifdef TEST_PATTERN_EN
    logic [2:0] bar1_q;
    logic       unused_vram;

    assign unused_vram = ^{red_in, green_in, blue_in};
    assign src         = bar1_q;

    // Bar index travels with the stage-1 flags
    always_ff @(posedge clk) begin
        if (reset) begin
            bar1_q <= '0;
        end else begin
            bar1_q <= col_q[COL_W-1:COL_W-3];
        end
    end
`else
    assign src = {red_in, green_in, blue_in};
`endif

    // Stage 1: VRAM address plus delayed blank/sync flags
    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= '0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
        end else begin
            address_q <= address_d;
            vis1_q    <= vis0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
        end
    end

    logic [3:0] red_q, green_q, blue_q;
    logic       hsync_q, vsync_q;

    // Stage 2: colours gated by blanking, registered with the syncs
    always_ff @(posedge clk) begin
        if (reset) begin
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            red_q   <= vis1_q ? {4{src[2]}} : 4'h0;
            green_q <= vis1_q ? {4{src[1]}} : 4'h0;
            blue_q  <= vis1_q ? {4{src[0]}} : 4'h0;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
        end
    end

    assign address   = address_q;
    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule
